// File: rtl/sram_arb_pkg.sv
// Shared state type, cartridge size limits and VP address mirroring for the SRAM arbiter.
// SRAM_ARB_READBACK_EN adds the post-write verify state.
package sram_arb_pkg;

    localparam logic [15:0] CART_2K_LIMIT = 16'h1000;
    localparam logic [15:0] CART_4K_LIMIT = 16'h2000;

`ifdef SRAM_ARB_READBACK_EN
    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWrSetup,
        StWrPulse,
        StWrHold,
        StVerify
    } arb_state_e;
`else
    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWrSetup,
        StWrPulse,
        StWrHold
    } arb_state_e;
`endif

    // Small carts alias their upper address bits back onto the loaded image.
    function automatic logic [12:0] mirror_addr(input logic [12:0] vp_addr,
                                                input logic [15:0] cart_size);
        logic gt2k;
        logic gt4k;
        gt2k = (cart_size >= CART_2K_LIMIT);
        gt4k = (cart_size >= CART_4K_LIMIT);
        return {vp_addr[12] & gt4k, vp_addr[11] & gt2k, vp_addr[10:0]};
    endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// Loadable down-counter that times each arbiter phase; done_o is high when the count is zero.
module sram_phase_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/sram_arbiter.sv
// Shares one 8-bit SRAM between timed loader writes and mirrored VP cartridge reads.
// Define SRAM_ARB_READBACK_EN to read back each write and flag mismatches on wr_err_o.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 19,
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned PULSE_CYC = 2,
    parameter int unsigned HOLD_CYC  = 1,
    parameter int unsigned RD_CYC    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_req_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [7:0]        ld_data_i,
    output logic              ld_ack_o,
    input  logic [12:0]       vp_addr_i,
    input  logic              vp_en_n_i,
    output logic [7:0]        vp_data_o,
    output logic              vp_valid_o,
    input  logic [15:0]       cart_size_i,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [7:0]        sram_dout_o,
    output logic              sram_doe_o,
    input  logic [7:0]        sram_din_i,
    output logic              sram_we_n_o,
    output logic              busy_o,
    output logic              wr_err_o
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] SetupLd = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PulseLd = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HoldLd  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] RdLd    = CNT_W'(RD_CYC - 1);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        dout_q, dout_d;
    logic [7:0]        vp_data_q, vp_data_d;
    logic              vp_valid_q, vp_valid_d;
    logic [12:0]       tag_q, tag_d;
    logic              tag_vld_q, tag_vld_d;

    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_val;
    logic              tmr_done;
    logic              capture;
    logic              ld_ack;
    logic [12:0]       eff_addr;
    logic              rd_req;

    sram_phase_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load_i    (tmr_load),
        .load_val_i(tmr_val),
        .done_o    (tmr_done)
    );

    assign eff_addr = mirror_addr(vp_addr_i, cart_size_i);
    // Re-reading an address already presented on vp_data is skipped.
    assign rd_req   = !vp_en_n_i && (!tag_vld_q || (eff_addr != tag_q));

`ifdef SRAM_ARB_READBACK_EN
    logic verify_chk;
    logic err_q, err_d;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        dout_d   = dout_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        capture  = 1'b0;
        ld_ack   = 1'b0;
`ifdef SRAM_ARB_READBACK_EN
        verify_chk = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (rd_req) begin
                    state_d  = StRd;
                    addr_d   = ADDR_W'(eff_addr);
                    tmr_load = 1'b1;
                    tmr_val  = RdLd;
                end else if (ld_req_i) begin
                    state_d  = StWrSetup;
                    addr_d   = ld_addr_i;
                    dout_d   = ld_data_i;
                    tmr_load = 1'b1;
                    tmr_val  = SetupLd;
                end
            end
            StRd: begin
                if (tmr_done) begin
                    capture = 1'b1;
                    state_d = StIdle;
                end
            end
            StWrSetup: begin
                if (tmr_done) begin
                    state_d  = StWrPulse;
                    tmr_load = 1'b1;
                    tmr_val  = PulseLd;
                end
            end
            StWrPulse: begin
                if (tmr_done) begin
                    state_d  = StWrHold;
                    tmr_load = 1'b1;
                    tmr_val  = HoldLd;
                end
            end
            StWrHold: begin
                if (tmr_done) begin
`ifdef SRAM_ARB_READBACK_EN
                    state_d  = StVerify;
                    tmr_load = 1'b1;
                    tmr_val  = RdLd;
`else
                    ld_ack  = 1'b1;
                    state_d = StIdle;
`endif
                end
            end
`ifdef SRAM_ARB_READBACK_EN
            StVerify: begin
                if (tmr_done) begin
                    verify_chk = 1'b1;
                    ld_ack     = 1'b1;
                    state_d    = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        vp_data_d  = vp_data_q;
        vp_valid_d = capture;
        tag_d      = tag_q;
        tag_vld_d  = tag_vld_q;
        if (vp_en_n_i) begin
            vp_data_d = 8'hFF;
            tag_vld_d = 1'b0;
        end else if (capture) begin
            vp_data_d = sram_din_i;
            tag_d     = addr_q[12:0];
            tag_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            dout_q     <= '0;
            vp_data_q  <= 8'hFF;
            vp_valid_q <= 1'b0;
            tag_q      <= '0;
            tag_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
            vp_data_q  <= vp_data_d;
            vp_valid_q <= vp_valid_d;
            tag_q      <= tag_d;
            tag_vld_q  <= tag_vld_d;
        end
    end

`ifdef SRAM_ARB_READBACK_EN
    assign err_d = err_q | (verify_chk && (sram_din_i != dout_q));

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign wr_err_o   = err_q;
    assign sram_doe_o = (state_q == StWrSetup) || (state_q == StWrPulse) ||
                        (state_q == StWrHold);
`else
    assign wr_err_o   = 1'b0;
    assign sram_doe_o = (state_q == StWrSetup) || (state_q == StWrPulse) ||
                        (state_q == StWrHold);
`endif

    assign sram_we_n_o = (state_q != StWrPulse);
    assign sram_addr_o = addr_q;
    assign sram_dout_o = dout_q;
    assign busy_o      = (state_q != StIdle);
    assign ld_ack_o    = ld_ack;
    assign vp_data_o   = vp_data_q;
    assign vp_valid_o  = vp_valid_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: transaction-schedule model, SRAM memory model, directed and random stimulus.
module tb_sram_arbiter;

    localparam int unsigned AW = 19;
    localparam int S = 1;
    localparam int P = 2;
    localparam int H = 1;
    localparam int R = 2;
`ifdef SRAM_ARB_READBACK_EN
    localparam int WLEN = S + P + H + R;
`else
    localparam int WLEN = S + P + H;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ld_req = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [7:0]    ld_data = '0;
    logic          ld_ack;
    logic [12:0]   vp_addr = '0;
    logic          vp_en_n = 1'b1;
    logic [7:0]    vp_data;
    logic          vp_valid;
    logic [15:0]   cart_size = 16'h2000;
    logic [AW-1:0] sram_addr;
    logic [7:0]    sram_dout;
    logic          sram_doe;
    logic [7:0]    sram_din;
    logic          sram_we_n;
    logic          busy;
    logic          wr_err;
    logic          corrupt = 1'b0;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    sram_arbiter u_dut (
        .clk        (clk),
        .reset      (reset),
        .ld_req_i   (ld_req),
        .ld_addr_i  (ld_addr),
        .ld_data_i  (ld_data),
        .ld_ack_o   (ld_ack),
        .vp_addr_i  (vp_addr),
        .vp_en_n_i  (vp_en_n),
        .vp_data_o  (vp_data),
        .vp_valid_o (vp_valid),
        .cart_size_i(cart_size),
        .sram_addr_o(sram_addr),
        .sram_dout_o(sram_dout),
        .sram_doe_o (sram_doe),
        .sram_din_i (sram_din),
        .sram_we_n_o(sram_we_n),
        .busy_o     (busy),
        .wr_err_o   (wr_err)
    );

    // External SRAM: written mid-cycle while we_n is low, read asynchronously.
    logic [7:0] mem     [0:(1<<AW)-1];
    logic [7:0] ref_mem [0:(1<<AW)-1];
    assign sram_din = mem[sram_addr] ^ {7'b0, corrupt};

    initial forever begin
        @(negedge clk);
        if (sram_we_n == 1'b0) mem[sram_addr] = sram_dout;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no response within cycle budget (t=%0t)", name, $time);
    endtask

    function automatic logic [12:0] model_eff(input logic [12:0] a, input logic [15:0] cs);
        int unsigned m;
        m = 32'h7FF;
        if (cs >= 16'h1000) m = m + 32'h800;
        if (cs >= 16'h2000) m = m + 32'h1000;
        return 13'(32'(a) & m);
    endfunction

    // Model: one transaction at a time, outputs derived from cycles elapsed since it began.
    int            m_op;  // 0 none, 1 read, 2 write
    int            m_k;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_dout;
    logic [7:0]    m_vdata;
    logic          m_vvalid;
    logic [12:0]   m_tag;
    logic          m_tag_v;
    logic          m_err;
    logic          m_cap;
    logic [12:0]   m_e;

    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_op = 0; m_k = 0; m_addr = '0; m_dout = '0; m_vdata = 8'hFF;
            m_vvalid = 1'b0; m_tag = '0; m_tag_v = 1'b0; m_err = 1'b0;
        end else begin
            m_cap = (m_op == 1) && (m_k == R - 1);
            if (m_op == 2 && m_k >= S && m_k < S + P) ref_mem[m_addr] = m_dout;
`ifdef SRAM_ARB_READBACK_EN
            if (m_op == 2 && m_k == WLEN - 1 && corrupt) m_err = 1'b1;
`endif
            m_vvalid = m_cap;
            if (m_op == 0) begin
                m_e = model_eff(vp_addr, cart_size);
                if (!vp_en_n && (!m_tag_v || m_e != m_tag)) begin
                    m_op = 1; m_k = 0; m_addr = AW'(m_e);
                end else if (ld_req) begin
                    m_op = 2; m_k = 0; m_addr = ld_addr; m_dout = ld_data;
                end
            end else begin
                m_k++;
                if (m_k == ((m_op == 1) ? R : WLEN)) m_op = 0;
            end
            if (vp_en_n) begin
                m_vdata = 8'hFF;
                m_tag_v = 1'b0;
            end else if (m_cap) begin
                m_vdata = ref_mem[AW'(m_tag_v ? m_addr : m_addr)] ^ {7'b0, corrupt};
                m_tag   = m_addr[12:0];
                m_tag_v = 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_op != 0));
            chk("we_n", 32'(sram_we_n), 32'(!(m_op == 2 && m_k >= S && m_k < S + P)));
            chk("doe", 32'(sram_doe), 32'(m_op == 2 && m_k < S + P + H));
            chk("ld_ack", 32'(ld_ack), 32'(m_op == 2 && m_k == WLEN - 1));
            chk("sram_addr", 32'(sram_addr), 32'(m_addr));
            chk("sram_dout", 32'(sram_dout), 32'(m_dout));
            chk("vp_data", 32'(vp_data), 32'(m_vdata));
            chk("vp_valid", 32'(vp_valid), 32'(m_vvalid));
            chk("wr_err", 32'(wr_err), 32'(m_err));
        end
    end

    task automatic do_write(input logic [AW-1:0] a, input logic [7:0] d, input logic with_vp,
                            input logic [12:0] va, output int lat, output int we_cyc,
                            output int setup_cyc);
        @(posedge clk); #1;
        ld_req = 1'b1; ld_addr = a; ld_data = d;
        if (with_vp) begin vp_addr = va; vp_en_n = 1'b0; end
        lat = 0; we_cyc = 0; setup_cyc = 0;
        for (int n = 1; n <= 64; n++) begin
            @(negedge clk);
            if (sram_doe && sram_we_n && we_cyc == 0) setup_cyc++;
            if (!sram_we_n) we_cyc++;
            if (ld_ack) begin lat = n; break; end
        end
        if (lat == 0) timeout("wr_ack");
        @(posedge clk); #1;
        ld_req = 1'b0;
    endtask

    task automatic do_read(input logic [12:0] a, input logic [15:0] cs,
                           output logic [AW-1:0] rd_addr, output int lat, output logic [7:0] d);
        int nb;
        nb = -1; lat = -1; rd_addr = '0; d = '0;
        @(posedge clk); #1;
        vp_addr = a; cart_size = cs; vp_en_n = 1'b0;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (busy && nb < 0) begin nb = n; rd_addr = sram_addr; end
            if (vp_valid) begin lat = n - nb; d = vp_data; break; end
        end
        if (lat < 0) timeout("rd_valid");
    endtask

    initial begin
        int lat, wc, sc, got, ack_seen;
        logic [AW-1:0] ra;
        logic [7:0] rd;

        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end

        @(posedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_vp_data", 32'(vp_data), 32'hFF);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Solo loader write
        do_write(19'h00010, 8'hA5, 1'b0, 13'h0, lat, wc, sc);
        chk("wr_ack_lat", 32'(lat), 32'(WLEN + 1));
        chk("wr_setup_cyc", 32'(sc), 32'd1);
        chk("wr_pulse_cyc", 32'(wc), 32'd2);
        chk("mem_a5", 32'(mem[19'h00010]), 32'hA5);

        // Mirroring of VP reads
        do_read(13'h1805, 16'h0800, ra, lat, rd);
        chk("mirror_2k", 32'(ra), 32'h00005);
        chk("rd_lat", 32'(lat), 32'd2);
        chk("rd_data", 32'(rd), 32'h26);
        do_read(13'h1805, 16'h2000, ra, lat, rd);
        chk("mirror_8k", 32'(ra), 32'h01805);

        // Simultaneous requests: read first, write delayed by RD_CYC + 1
        @(posedge clk); #1; vp_en_n = 1'b1;
        do_write(19'h00020, 8'h11, 1'b1, 13'h0042, lat, wc, sc);
        chk("both_ack_lat", 32'(lat), 32'(WLEN + 1 + R + 1));

        // VP request arriving during the write pulse
        @(posedge clk); #1; vp_en_n = 1'b1;
        fork
            do_write(19'h00123, 8'h3C, 1'b0, 13'h0, lat, wc, sc);
            begin
                got = 0;
                for (int n = 0; n < 64; n++) begin
                    @(negedge clk);
                    if (!sram_we_n) begin got = 1; break; end
                end
                if (got == 0) timeout("pulse_wait");
                @(posedge clk); #1;
                vp_addr = 13'h0123; vp_en_n = 1'b0;
            end
        join
        chk("midwr_ack_lat", 32'(lat), 32'(WLEN + 1));
        chk("midwr_pulse_cyc", 32'(wc), 32'd2);
        got = 0;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (vp_valid) begin got = 1; chk("midwr_rd_data", 32'(vp_data), 32'h3C); break; end
        end
        if (got == 0) timeout("midwr_rd");

        // Reset during the write pulse
        @(posedge clk); #1;
        vp_en_n = 1'b1; ld_req = 1'b1; ld_addr = 19'h00200; ld_data = 8'h77;
        got = 0;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (!sram_we_n) begin got = 1; break; end
        end
        if (got == 0) timeout("rst_pulse_wait");
        @(posedge clk); #1;
        reset = 1'b1; ld_req = 1'b0;
        @(posedge clk); #1;
        chk("rstwr_we_n", 32'(sram_we_n), 32'd1);
        chk("rstwr_doe", 32'(sram_doe), 32'd0);
        chk("rstwr_ack", 32'(ld_ack), 32'd0);
        chk("rstwr_busy", 32'(busy), 32'd0);
        reset = 1'b0;

`ifdef SRAM_ARB_READBACK_EN
        corrupt = 1'b1;
        do_write(19'h00300, 8'h5A, 1'b0, 13'h0, lat, wc, sc);
        corrupt = 1'b0;
        chk("rb_err_set", 32'(wr_err), 32'd1);
        do_write(19'h00301, 8'h5B, 1'b0, 13'h0, lat, wc, sc);
        chk("rb_err_sticky", 32'(wr_err), 32'd1);
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        chk("rb_err_clr", 32'(wr_err), 32'd0);
`endif

        // Randomized traffic with the loader handshake obeyed
        ack_seen = 0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            if (ack_seen != 0) begin
                ld_req = 1'b0; ack_seen = 0;
            end else if (!ld_req && $urandom_range(3) == 0) begin
                ld_req  = 1'b1;
                ld_addr = ($urandom_range(7) == 0) ? AW'($urandom) : AW'($urandom_range(31));
                ld_data = 8'($urandom);
            end
            if ($urandom_range(7) == 0) vp_en_n = ~vp_en_n;
            if ($urandom_range(5) == 0) vp_addr = 13'($urandom_range(31)) | 13'($urandom_range(3) << 11);
            if ($urandom_range(63) == 0) begin
                case ($urandom_range(3))
                    0: cart_size = 16'h0800;
                    1: cart_size = 16'h1000;
                    2: cart_size = 16'h2000;
                    default: cart_size = 16'($urandom);
                endcase
            end
            @(negedge clk);
            if (ld_ack) ack_seen = 1;
        end
        if (ack_seen == 0 && ld_req) begin
            got = 0;
            for (int n = 0; n < 64; n++) begin
                @(negedge clk);
                if (ld_ack) begin got = 1; break; end
            end
            if (got == 0) timeout("drain_ack");
        end
        @(posedge clk); #1;
        ld_req = 1'b0; vp_en_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("end_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
